// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program counter and instruction-fetch stage sitting directly in front of a
//   combinational program memory. The PC drives the PM address. The returned
//   word is either resolved locally (JMP, opcode 4'hF) or captured into the
//   instruction register and offered to the decoder over a valid/ready
//   handshake. A saturating counter records every accepted handshake.
//
// Parameters
//   DATA_WIDTH  instruction width; [DW-1 -: 4] opcode, [3 +: ADDR_WIDTH] JMP target
//   ADDR_WIDTH  PC / PM address width
//   RESET_ADDR  PC value after reset
//   NOP_WORD    IR contents after reset
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   EN         in   run enable; low parks the stage in IDLE
//   STALL      in   freeze: all state holds, no handshake accepted
//   PM_ADDR    out  address to PM, equals the PC register
//   PM_DATA    in   instruction from PM, valid in the same cycle
//   IR_OUT     out  captured instruction to the decoder
//   IR_VALID   out  IR_OUT holds an instruction not yet accepted
//   ID_READY   in   decoder ready; accept = IR_VALID & ID_READY & !STALL
//   PC_OUT     out  address of the instruction currently in IR
//   JMP_TAKEN  out  one-cycle pulse in the cycle after a JMP fetch
//   RETIRED    out  accepted-handshake count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int unsigned                 DATA_WIDTH = 16,
  parameter int unsigned                 ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0]       RESET_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0]       NOP_WORD   = DATA_WIDTH'(16'hA000)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  STALL,
  output logic [ADDR_WIDTH-1:0] PM_ADDR,
  input  logic [DATA_WIDTH-1:0] PM_DATA,
  output logic [DATA_WIDTH-1:0] IR_OUT,
  output logic                  IR_VALID,
  input  logic                  ID_READY,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  JMP_TAKEN,
  output logic [15:0]           RETIRED
);

  localparam logic [3:0] OP_JMP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   pc_q,      pc_d;
  logic [DATA_WIDTH-1:0]   ir_q,      ir_d;
  logic [ADDR_WIDTH-1:0]   pc_out_q,  pc_out_d;
  logic                    valid_q,   valid_d;
  logic                    jmp_q,     jmp_d;
  logic [15:0]             retired_q, retired_d;

  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   jmp_target;
  logic                    is_jmp;

  assign opcode     = PM_DATA[DATA_WIDTH-1 -: 4];
  assign jmp_target = PM_DATA[3 +: ADDR_WIDTH];
  assign is_jmp     = (opcode == OP_JMP);

  // Next-state and datapath updates. STALL suppresses every update, so the
  // defaults below (hold everything, no jump pulse) are the stalled behaviour.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    retired_d = retired_q;
    jmp_d     = 1'b0;

    if (!STALL) begin
      unique case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          if (EN) begin
            state_d = S_FETCH;
          end
        end

        S_FETCH: begin
          if (!EN) begin
            state_d = S_IDLE;
          end else if (is_jmp) begin
            // JMP is consumed here: redirect the PC and stay in FETCH.
            pc_d  = jmp_target;
            jmp_d = 1'b1;
          end else begin
            ir_d     = PM_DATA;
            pc_out_d = pc_q;
            pc_d     = pc_q + 1'b1;
            valid_d  = 1'b1;
            state_d  = S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (valid_q && ID_READY) begin
            valid_d = 1'b0;
            if (retired_q != '1) begin
              retired_d = retired_q + 16'd1;
            end
            state_d = EN ? S_FETCH : S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_ADDR;
      ir_q      <= NOP_WORD;
      pc_out_q  <= RESET_ADDR;
      valid_q   <= 1'b0;
      jmp_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      jmp_q     <= jmp_d;
      retired_q <= retired_d;
    end
  end

  assign PM_ADDR   = pc_q;
  assign IR_OUT    = ir_q;
  assign IR_VALID  = valid_q;
  assign PC_OUT    = pc_out_q;
  // Masked so the pulse is never visible while the stage is frozen.
  assign JMP_TAKEN = jmp_q & ~STALL;
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//   Bench for pc_fetch: a directed vector table, hand-written multi-cycle
//   sequences (wrap, backpressure, stall, reset, counter saturation) and a
//   randomized run compared against a behavioural model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        STALL;
  logic [4:0]  PM_ADDR;
  logic [15:0] PM_DATA;
  logic [15:0] IR_OUT;
  logic        IR_VALID;
  logic        ID_READY;
  logic [4:0]  PC_OUT;
  logic        JMP_TAKEN;
  logic [15:0] RETIRED;

  logic [15:0] pm [32];

  int unsigned n_chk;
  int unsigned n_err;

  pc_fetch #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (5),
    .RESET_ADDR (5'd0),
    .NOP_WORD   (16'hA000)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .STALL     (STALL),
    .PM_ADDR   (PM_ADDR),
    .PM_DATA   (PM_DATA),
    .IR_OUT    (IR_OUT),
    .IR_VALID  (IR_VALID),
    .ID_READY  (ID_READY),
    .PC_OUT    (PC_OUT),
    .JMP_TAKEN (JMP_TAKEN),
    .RETIRED   (RETIRED)
  );

  assign PM_DATA = pm[PM_ADDR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one clock and return at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".addr"},  64'(PM_ADDR),   64'd0);
    chk({nm, ".ir"},    64'(IR_OUT),    64'hA000);
    chk({nm, ".pco"},   64'(PC_OUT),    64'd0);
    chk({nm, ".valid"}, 64'(IR_VALID),  64'd0);
    chk({nm, ".jmp"},   64'(JMP_TAKEN), 64'd0);
    chk({nm, ".ret"},   64'(RETIRED),   64'd0);
  endtask

  // Reset asserted mid-cycle, checked before any clock edge, released at negedge.
  task automatic do_reset(input string nm);
    #2 RST_N = 1'b0;
    #1 chk_reset_vals(nm);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++) pm[i] = 16'h1000 + 16'(i);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        en;
    logic        stall;
    logic        rdy;
    logic [4:0]  addr;
    logic        v;
    logic [4:0]  pco;
    logic [15:0] ir;
    logic        jt;
    logic [15:0] ret;
  } vec_t;

  vec_t vt [22];

  // ---------------------------------------------------------------------------
  // Behavioural model: the stage is either parked, looking for an instruction,
  // or holding one for the decoder.
  // ---------------------------------------------------------------------------
  logic        m_running;
  logic        m_holding;
  logic [4:0]  m_pc;
  logic [15:0] m_ir;
  logic [4:0]  m_pco;
  logic        m_jt;
  logic [15:0] m_ret;

  task automatic model_reset();
    m_running = 1'b0;
    m_holding = 1'b0;
    m_pc      = 5'd0;
    m_ir      = 16'hA000;
    m_pco     = 5'd0;
    m_jt      = 1'b0;
    m_ret     = 16'd0;
  endtask

  task automatic model_step(input logic en, input logic stall, input logic rdy);
    logic [15:0] w;
    m_jt = 1'b0;
    if (stall) return;
    if (m_holding) begin
      if (rdy) begin
        m_holding = 1'b0;
        if (m_ret < 16'hFFFF) m_ret = m_ret + 16'd1;
        m_running = en;
      end
    end else if (!m_running) begin
      m_running = en;
    end else if (!en) begin
      m_running = 1'b0;
    end else begin
      w = pm[m_pc];
      if (w[15:12] == 4'hF) begin
        m_pc = w[7:3];
        m_jt = 1'b1;
      end else begin
        m_ir      = w;
        m_pco     = m_pc;
        m_pc      = 5'((32'(m_pc) + 1) % 32);
        m_holding = 1'b1;
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    RST_N    = 1'b0;
    EN       = 1'b0;
    STALL    = 1'b0;
    ID_READY = 1'b0;
    fill_linear();
    pm[7] = 16'hF020;   // JMP 4

    //                en stl rdy addr   v  pco    ir        jt ret
    vt[0]  = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 16'hA000, 1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 16'h1000, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 16'h1000, 1'b0, 16'd1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 5'd1, 16'h1001, 1'b0, 16'd1};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 5'd1, 16'h1001, 1'b0, 16'd2};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd2, 16'h1002, 1'b0, 16'd2};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd2, 16'h1002, 1'b0, 16'd3};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 5'd3, 16'h1003, 1'b0, 16'd3};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd3, 16'h1003, 1'b0, 16'd4};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd4, 16'h1004, 1'b0, 16'd4};
    vt[10] = '{1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd4, 16'h1004, 1'b0, 16'd5};
    vt[11] = '{1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5, 16'h1005, 1'b0, 16'd5};
    vt[12] = '{1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'd5, 16'h1005, 1'b0, 16'd6};
    vt[13] = '{1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd6, 16'h1006, 1'b0, 16'd6};
    vt[14] = '{1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd6, 16'h1006, 1'b0, 16'd7};
    vt[15] = '{1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd6, 16'h1006, 1'b1, 16'd7};
    vt[16] = '{1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd4, 16'h1004, 1'b0, 16'd7};
    vt[17] = '{1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd4, 16'h1004, 1'b0, 16'd8};
    vt[18] = '{1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd4, 16'h1004, 1'b0, 16'd8};
    vt[19] = '{1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd4, 16'h1004, 1'b0, 16'd8};
    vt[20] = '{1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd4, 16'h1004, 1'b0, 16'd8};
    vt[21] = '{1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5, 16'h1005, 1'b0, 16'd8};

    // Reset state, then a mid-cycle asynchronous reset
    @(negedge CLK);
    chk_reset_vals("rst0");
    RST_N = 1'b1;
    tick();
    do_reset("rst_async");

    // Sequential issue and JMP 4 from address 7
    for (int i = 0; i < 22; i++) begin
      EN = vt[i].en; STALL = vt[i].stall; ID_READY = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d.addr", i),  64'(PM_ADDR),   64'(vt[i].addr));
      chk($sformatf("vec%0d.valid", i), 64'(IR_VALID),  64'(vt[i].v));
      chk($sformatf("vec%0d.pco", i),   64'(PC_OUT),    64'(vt[i].pco));
      chk($sformatf("vec%0d.ir", i),    64'(IR_OUT),    64'(vt[i].ir));
      chk($sformatf("vec%0d.jmp", i),   64'(JMP_TAKEN), 64'(vt[i].jt));
      chk($sformatf("vec%0d.ret", i),   64'(RETIRED),   64'(vt[i].ret));
    end

    // PC wrap at 31 and backpressure
    EN = 1'b0; STALL = 1'b0; ID_READY = 1'b0;
    fill_linear();
    pm[0]  = 16'hF0F8;  // JMP 31
    pm[31] = 16'h31AB;
    do_reset("rst_wrap");
    EN = 1'b1;
    tick();
    tick();
    chk("wrap.jmp_addr", 64'(PM_ADDR), 64'd31);
    chk("wrap.jmp_pulse", 64'(JMP_TAKEN), 64'd1);
    tick();
    chk("wrap.addr", 64'(PM_ADDR), 64'd0);
    chk("wrap.jmp_clr", 64'(JMP_TAKEN), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d.valid", i), 64'(IR_VALID), 64'd1);
      chk($sformatf("bp%0d.ir", i),    64'(IR_OUT),   64'h31AB);
      chk($sformatf("bp%0d.pco", i),   64'(PC_OUT),   64'd31);
      chk($sformatf("bp%0d.ret", i),   64'(RETIRED),  64'd0);
    end
    ID_READY = 1'b1;
    tick();
    chk("bp.release.valid", 64'(IR_VALID), 64'd0);
    chk("bp.release.ret",   64'(RETIRED),  64'd1);
    ID_READY = 1'b0;
    tick();
    tick();
    chk("wrap2.valid", 64'(IR_VALID), 64'd1);

    // STALL blocks the handshake; EN=0 at accept parks the stage
    STALL = 1'b1; ID_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d.valid", i), 64'(IR_VALID), 64'd1);
      chk($sformatf("stall%0d.ret", i),   64'(RETIRED),  64'd1);
      chk($sformatf("stall%0d.addr", i),  64'(PM_ADDR),  64'd0);
    end
    STALL = 1'b0; EN = 1'b0;
    tick();
    chk("en0.valid", 64'(IR_VALID), 64'd0);
    chk("en0.ret",   64'(RETIRED),  64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle%0d.addr", i), 64'(PM_ADDR), 64'd0);
      chk($sformatf("idle%0d.ret", i),  64'(RETIRED), 64'd2);
    end

    // Reset while an instruction is waiting, PC=6
    fill_linear();
    pm[0] = 16'hF028;   // JMP 5
    do_reset("rst_pre");
    EN = 1'b1; ID_READY = 1'b0;
    tick();
    tick();
    tick();
    chk("issue6.addr",  64'(PM_ADDR),  64'd6);
    chk("issue6.valid", 64'(IR_VALID), 64'd1);
    chk("issue6.pco",   64'(PC_OUT),   64'd5);
    do_reset("rst_issue");

    // Counter saturation from a forced preload
    EN = 1'b0; ID_READY = 1'b1;
    fill_linear();
    force dut.retired_q = 16'hFFFD;
    tick();
    tick();
    release dut.retired_q;
    tick();
    chk("sat.preload", 64'(RETIRED), 64'hFFFD);
    EN = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      chk($sformatf("sat%0d.ret", i), 64'(RETIRED),
          (i == 0) ? 64'hFFFE : 64'hFFFF);
    end

    // Randomized run against the model
    EN = 1'b0; STALL = 1'b0; ID_READY = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0)
        pm[i] = {4'hF, 4'($urandom), 5'($urandom_range(0, 31)), 3'($urandom)};
      else
        pm[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    do_reset("rst_rand");
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      EN       = ($urandom_range(0, 7) != 0);
      STALL    = ($urandom_range(0, 5) == 0);
      ID_READY = ($urandom_range(0, 2) != 0);
      tick();
      model_step(EN, STALL, ID_READY);
      chk($sformatf("rand%0d {addr,v,pco,ir,jt,ret}", c),
          {20'd0, PM_ADDR, IR_VALID, PC_OUT, IR_OUT, JMP_TAKEN, RETIRED},
          {20'd0, m_pc, m_holding, m_pco, m_ir, m_jt, m_ret});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
